page_reconfig_sequencer: RTL and testbench
==========================================

# page_reconfig_sequencer

Sequences dynamic partial reconfiguration of the leaf pages hanging off one BFT leaf cluster, such as the two child pages of a subdivided parent page. It arbitrates round-robin between per-page reconfiguration requests and shares the single DFX/ICAP controller between them. For the granted page it isolates and resets the page, triggers reconfiguration, then releases reset and starts the page. It sits between the host/control network and the pages' `reset`, `ap_start`, `resend` and `dout_leaf_interface2bft` connections.

## Interface
- `NUM_PAGES`, 2: number of managed pages (2..8).
- `PKT_W`, 49: leaf packet width.
- `ISO_CYCLES`, 8: cycles spent isolated and in reset before DFX trigger (≥1).
- `RST_HOLD`, 16: cycles reset stays asserted after DFX done (≥1).
- `START_DELAY`, 4: cycles between reset release and `ap_start` (≥1).
- `TIMEOUT`, 1_000_000: max cycles waiting for DFX done/error (≥2).
- `SEL_W`, derived: max(1, clog2(NUM_PAGES)).

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `reconf_req`, in, NUM_PAGES: level request per page; held until the matching `reconf_ack`.
- `reconf_ack`, out, NUM_PAGES: one-cycle pulse when a page resumes or its attempt fails.
- `dfx_trigger`, out, 1: one-cycle pulse that starts the DFX controller.
- `dfx_page_sel`, out, SEL_W: granted page index; stable throughout the job.
- `dfx_done`, in, 1: one-cycle pulse reporting a successful load.
- `dfx_error`, in, 1: one-cycle pulse reporting a failed load.
- `page_reset`, out, NUM_PAGES: active-high reset to each page.
- `page_ap_start`, out, NUM_PAGES: one-cycle start pulse to each page.
- `page_resend`, out, NUM_PAGES: one-cycle resend pulse to each page.
- `dout_in`, in, NUM_PAGES*PKT_W: concatenated `dout_leaf_interface2bft` from the pages; page i occupies bits [i*PKT_W +: PKT_W].
- `dout_out`, out, NUM_PAGES*PKT_W: isolated copy of `dout_in` driven toward the BFT.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `err_flag`, out, NUM_PAGES: sticky per-page failure flag.

## Operation
- FSM states: IDLE, ISOLATE, RECONF, HOLD, RELEASE, START, FAIL.
- IDLE:
  - If any `reconf_req` bit is set, grant round-robin starting after the last granted index. After reset the pointer makes page 0 highest priority.
  - Latch the grant into `dfx_page_sel`.
  - Set the page's `page_reset` and isolation bit, then go to ISOLATE.
- ISOLATE: wait ISO_CYCLES cycles, then go to RECONF.
- RECONF:
  - `dfx_trigger` is high in the first RECONF cycle only.
  - On `dfx_done`, go to HOLD.
  - On `dfx_error`, or when TIMEOUT cycles elapse with neither, go to FAIL.
  - `dfx_done` and `dfx_error` in the same cycle count as error.
  - `dfx_done`/`dfx_error` arriving outside RECONF are ignored.
- HOLD: reset stays asserted for RST_HOLD cycles, then go to RELEASE and clear `page_reset[sel]`.
- RELEASE: wait START_DELAY cycles, then go to START.
- START (one cycle):
  - Pulse `page_ap_start[sel]` and `reconf_ack[sel]`.
  - Pulse `page_resend` on every other page that is not isolated.
  - Clear the isolation bit and `err_flag[sel]`.
  - Return to IDLE.
- FAIL (one cycle):
  - Set `err_flag[sel]` and pulse `reconf_ack[sel]`.
  - The page stays in reset and isolated; only a new successful job releases it.
  - Return to IDLE.
- Isolation: `dout_out` slice i = 0 while page i is isolated, otherwise `dout_in` slice i. This path is combinational from the registered isolation bit.
- Requests:
  - A request deasserted mid-job does not abort the job.
  - A request still high after its ack is re-granted by round-robin.
  - Only one job is in flight at a time.

## Timing
- Reset values: `page_reset`=0, isolation=0, `page_ap_start`=0, `page_resend`=0, `reconf_ack`=0, `dfx_trigger`=0, `dfx_page_sel`=0, `busy`=0, `err_flag`=0, RR pointer set so page 0 wins, FSM=IDLE.
- All outputs except `dout_out` are registered.
- Request seen in IDLE at edge t:
  - `page_reset`, isolation and `busy` are high from t+1.
  - `dfx_trigger` is high in cycle t+1+ISO_CYCLES.
- `dfx_done` sampled at edge d: `page_reset[sel]` falls at d+RST_HOLD+1.
- `page_ap_start`, `reconf_ack` and `page_resend` are high exactly START_DELAY cycles after reset falls; isolation clears in the same cycle.
- `busy` is low from the cycle after START/FAIL.
- Asserting `reset_n` mid-job immediately returns every output to its reset value. Pages are released from reset and isolation, so software must re-request.
- Counters are sized to hold the largest parameter and saturate; none wrap.

## Test plan
- NUM_PAGES=2, ISO_CYCLES=2, RST_HOLD=4, START_DELAY=2. `reconf_req`=01; `dfx_done` 5 cycles after trigger -> trigger 3 cycles after req; `page_reset[0]` high 2+1+5+4 cycles; `ap_start[0]`, `ack[0]`, `resend[1]` pulse 2 cycles after reset falls; `dout_out[48:0]`=0 while isolated.
- `reconf_req`=11 held through both jobs -> page 0 served then page 1; each ack once; page 1 never in reset during page 0's job.
- `dfx_error` in RECONF -> `err_flag[0]`=1, `ack[0]` pulse, `page_reset[0]` stays 1, `dout_out` slice stays 0, `busy` drops. A retry ending in `dfx_done` clears `err_flag[0]` and releases the page.
- TIMEOUT=20 with no done/error -> FAIL entered 20 cycles after trigger; simultaneous `dfx_done`+`dfx_error` -> FAIL.
- `reset_n` pulsed low during HOLD -> all outputs reset asynchronously; stray `dfx_done` arriving in IDLE is ignored.
- `dout_in`=all-ones on both pages, page 1 isolated -> `dout_out` = {49'h0, 49'h1FFFFFFFFFFFF}; page 0 unaffected throughout.

Source files
------------

// File: rtl/page_reconfig_sequencer.sv
// Reconfiguration sequencer for the leaf pages of one BFT leaf cluster.
// Grants pages round-robin, isolates and resets the page, drives the shared DFX controller, then restarts it.
module page_reconfig_sequencer #(
    parameter int unsigned NUM_PAGES   = 2,
    parameter int unsigned PKT_W       = 49,
    parameter int unsigned ISO_CYCLES  = 8,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned START_DELAY = 4,
    parameter int unsigned TIMEOUT     = 1_000_000,
    localparam int unsigned SEL_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_PAGES-1:0]       reconf_req,
    output logic [NUM_PAGES-1:0]       reconf_ack,
    output logic                       dfx_trigger,
    output logic [SEL_W-1:0]           dfx_page_sel,
    input  logic                       dfx_done,
    input  logic                       dfx_error,
    output logic [NUM_PAGES-1:0]       page_reset,
    output logic [NUM_PAGES-1:0]       page_ap_start,
    output logic [NUM_PAGES-1:0]       page_resend,
    input  logic [NUM_PAGES*PKT_W-1:0] dout_in,
    output logic [NUM_PAGES*PKT_W-1:0] dout_out,
    output logic                       busy,
    output logic [NUM_PAGES-1:0]       err_flag
);

    localparam int unsigned MAX_A   = (ISO_CYCLES > RST_HOLD) ? ISO_CYCLES : RST_HOLD;
    localparam int unsigned MAX_B   = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISOLATE, S_RECONF, S_HOLD, S_RELEASE, S_START, S_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [SEL_W-1:0]     rr_q, rr_d, sel_d, grant_idx;
    logic                 grant_vld;
    logic [NUM_PAGES-1:0] iso_q, iso_d, sel_mask;
    logic [NUM_PAGES-1:0] page_reset_d, err_d, ap_start_d, resend_d, ack_d;
    logic                 trigger_d, busy_d;

    // Index rr_q+off modulo NUM_PAGES, without a divider.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_PAGES) s = s - NUM_PAGES;
        return SEL_W'(s);
    endfunction

    // Round-robin arbiter: search starts just after the last granted page.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= NUM_PAGES; i++) begin
            if (!grant_vld && reconf_req[rr_index(rr_q, i)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_index(rr_q, i);
            end
        end
    end

    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign sel_mask = NUM_PAGES'(1) << dfx_page_sel;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        sel_d        = dfx_page_sel;
        rr_d         = rr_q;
        iso_d        = iso_q;
        page_reset_d = page_reset;
        err_d        = err_flag;
        trigger_d    = 1'b0;
        ap_start_d   = '0;
        resend_d     = '0;
        ack_d        = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_vld) begin
                    state_d                 = S_ISOLATE;
                    sel_d                   = grant_idx;
                    rr_d                    = grant_idx;
                    page_reset_d[grant_idx] = 1'b1;
                    iso_d[grant_idx]        = 1'b1;
                end
            end
            S_ISOLATE: begin
                if (cnt_q == CNT_W'(ISO_CYCLES - 1)) begin
                    state_d   = S_RECONF;
                    cnt_d     = '0;
                    trigger_d = 1'b1;
                end
            end
            S_RECONF: begin
                // A simultaneous done+error counts as an error.
                if (dfx_error || (!dfx_done && cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d             = S_FAIL;
                    err_d[dfx_page_sel] = 1'b1;
                    ack_d[dfx_page_sel] = 1'b1;
                end else if (dfx_done) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d                    = S_RELEASE;
                    cnt_d                      = '0;
                    page_reset_d[dfx_page_sel] = 1'b0;
                end
            end
            S_RELEASE: begin
                if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                    state_d                  = S_START;
                    ap_start_d[dfx_page_sel] = 1'b1;
                    ack_d[dfx_page_sel]      = 1'b1;
                    resend_d                 = ~iso_q & ~sel_mask;
                    iso_d[dfx_page_sel]      = 1'b0;
                    err_d[dfx_page_sel]      = 1'b0;
                end
            end
            S_START:  state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rr_q          <= SEL_W'(NUM_PAGES - 1);
            iso_q         <= '0;
            dfx_page_sel  <= '0;
            page_reset    <= '0;
            err_flag      <= '0;
            dfx_trigger   <= 1'b0;
            page_ap_start <= '0;
            page_resend   <= '0;
            reconf_ack    <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            iso_q         <= iso_d;
            dfx_page_sel  <= sel_d;
            page_reset    <= page_reset_d;
            err_flag      <= err_d;
            dfx_trigger   <= trigger_d;
            page_ap_start <= ap_start_d;
            page_resend   <= resend_d;
            reconf_ack    <= ack_d;
            busy          <= busy_d;
        end
    end

    // Isolated pages present an all-zero word to the BFT.
    for (genvar g = 0; g < NUM_PAGES; g++) begin : g_iso
        assign dout_out[g*PKT_W +: PKT_W] = iso_q[g] ? '0 : dout_in[g*PKT_W +: PKT_W];
    end

endmodule

// File: tb/tb_page_reconfig_sequencer.sv
// Directed self-checking bench for page_reconfig_sequencer (2 pages, short timings).
module tb_page_reconfig_sequencer;

    localparam int unsigned NP = 2;
    localparam int unsigned PW = 49;

    logic              clk;
    logic              reset_n;
    logic [NP-1:0]     reconf_req;
    logic [NP-1:0]     reconf_ack;
    logic              dfx_trigger;
    logic [0:0]        dfx_page_sel;
    logic              dfx_done;
    logic              dfx_error;
    logic [NP-1:0]     page_reset;
    logic [NP-1:0]     page_ap_start;
    logic [NP-1:0]     page_resend;
    logic [NP*PW-1:0]  dout_in;
    logic [NP*PW-1:0]  dout_out;
    logic              busy;
    logic [NP-1:0]     err_flag;

    logic [PW-1:0]     ones49;
    logic [PW-1:0]     pat49;
    logic [NP*PW-1:0]  exp_iso1;
    int                n_checks;
    int                n_pass;
    int                n;
    int                o;

    page_reconfig_sequencer #(
        .NUM_PAGES(2), .PKT_W(49), .ISO_CYCLES(2), .RST_HOLD(4),
        .START_DELAY(2), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .reconf_req(reconf_req), .reconf_ack(reconf_ack),
        .dfx_trigger(dfx_trigger), .dfx_page_sel(dfx_page_sel), .dfx_done(dfx_done),
        .dfx_error(dfx_error), .page_reset(page_reset), .page_ap_start(page_ap_start),
        .page_resend(page_resend), .dout_in(dout_in), .dout_out(dout_out),
        .busy(busy), .err_flag(err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_trig(output int cyc);
        cyc = 0;
        while (!dfx_trigger && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!dfx_trigger) cyc = -1;
    endtask

    // Counts cycles to the next ack and cycles where a page in 'other' is held in reset.
    task automatic wait_ack(input logic [NP-1:0] other, output int cyc, output int other_rst);
        cyc = 0;
        other_rst = 0;
        while (reconf_ack == '0 && cyc < 60) begin
            tick();
            cyc++;
            if ((page_reset & other) != '0) other_rst++;
        end
        if (reconf_ack == '0) cyc = -1;
    endtask

    task automatic pulse_done();
        dfx_done = 1'b1;
        tick();
        dfx_done = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        ones49 = '1;
        pat49 = 49'h1_2345_6789_ABCD;
        exp_iso1 = {49'h0, ones49};
        reconf_req = '0;
        dfx_done = 1'b0;
        dfx_error = 1'b0;
        dout_in = '1;
        do_reset();

        // Reset state
        check("rst_page_reset", page_reset, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_sel", dfx_page_sel, 1'b0);
        check("rst_err", err_flag, 2'b00);
        check("rst_dout", dout_out, {ones49, ones49});

        // Single successful job on page 0
        reconf_req = 2'b01;
        tick();
        check("j1_reset_rise", page_reset, 2'b01);
        check("j1_busy", busy, 1'b1);
        check("j1_iso_slice0", dout_out[48:0], 49'h0);
        check("j1_slice1_pass", dout_out[97:49], ones49);
        wait_trig(n);
        check("j1_trig_latency", n, 2);
        reconf_req = 2'b00;
        tick();
        check("j1_trig_one_cycle", dfx_trigger, 1'b0);
        repeat (3) tick();
        pulse_done();
        repeat (3) tick();
        check("j1_reset_held", page_reset, 2'b01);
        tick();
        check("j1_reset_fall", page_reset, 2'b00);
        check("j1_still_iso", dout_out[48:0], 49'h0);
        tick();
        check("j1_no_early_start", page_ap_start, 2'b00);
        tick();
        check("j1_ap_start", page_ap_start, 2'b01);
        check("j1_ack", reconf_ack, 2'b01);
        check("j1_resend", page_resend, 2'b10);
        check("j1_iso_clear", dout_out[48:0], ones49);
        tick();
        check("j1_ack_pulse", reconf_ack, 2'b00);
        check("j1_busy_low", busy, 1'b0);

        // Both pages requesting: page 0 then page 1
        do_reset();
        reconf_req = 2'b11;
        tick();
        check("rr_first_sel", dfx_page_sel, 1'b0);
        check("rr_first_reset", page_reset, 2'b01);
        wait_trig(n);
        pulse_done();
        wait_ack(2'b10, n, o);
        check("rr_done_to_ack", n, 6);
        check("rr_ack0", reconf_ack, 2'b01);
        check("rr_p1_not_reset", o, 0);
        tick();
        check("rr_gap_idle", busy, 1'b0);
        tick();
        check("rr_second_sel", dfx_page_sel, 1'b1);
        check("rr_second_reset", page_reset, 2'b10);
        wait_trig(n);
        pulse_done();
        wait_ack(2'b01, n, o);
        check("rr_ack1", reconf_ack, 2'b10);
        check("rr_resend0", page_resend, 2'b01);
        check("rr_p0_not_reset", o, 0);
        reconf_req = 2'b00;
        repeat (2) tick();
        check("rr_end_idle", busy, 1'b0);

        // Error then successful retry
        reconf_req = 2'b01;
        tick();
        wait_trig(n);
        dfx_error = 1'b1;
        tick();
        dfx_error = 1'b0;
        reconf_req = 2'b00;
        check("er_flag", err_flag, 2'b01);
        check("er_ack", reconf_ack, 2'b01);
        check("er_no_start", page_ap_start, 2'b00);
        tick();
        check("er_busy_low", busy, 1'b0);
        check("er_reset_kept", page_reset, 2'b01);
        check("er_iso_kept", dout_out[48:0], 49'h0);
        reconf_req = 2'b01;
        tick();
        wait_trig(n);
        pulse_done();
        wait_ack(2'b10, n, o);
        check("er_retry_ack", reconf_ack, 2'b01);
        check("er_retry_clear", err_flag, 2'b00);
        check("er_retry_release", page_reset, 2'b00);
        reconf_req = 2'b00;
        tick();

        // Timeout, then simultaneous done+error
        reconf_req = 2'b01;
        tick();
        wait_trig(n);
        wait_ack(2'b10, n, o);
        check("to_latency", n, 20);
        check("to_err", err_flag, 2'b01);
        reconf_req = 2'b00;
        tick();
        reconf_req = 2'b01;
        tick();
        wait_trig(n);
        dfx_done = 1'b1;
        dfx_error = 1'b1;
        tick();
        dfx_done = 1'b0;
        dfx_error = 1'b0;
        reconf_req = 2'b00;
        check("both_ack", reconf_ack, 2'b01);
        check("both_err", err_flag, 2'b01);
        check("both_reset", page_reset, 2'b01);
        tick();

        // Asynchronous reset during HOLD, stray done in IDLE
        do_reset();
        reconf_req = 2'b10;
        tick();
        check("ar_sel", dfx_page_sel, 1'b1);
        wait_trig(n);
        pulse_done();
        tick();
        check("ar_in_hold", page_reset, 2'b10);
        reconf_req = 2'b00;
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_page_reset", page_reset, 2'b00);
        check("ar_busy", busy, 1'b0);
        check("ar_sel_clr", dfx_page_sel, 1'b0);
        check("ar_dout", dout_out, {ones49, ones49});
        reset_n = 1'b1;
        tick();
        pulse_done();
        tick();
        check("stray_busy", busy, 1'b0);
        check("stray_reset", page_reset, 2'b00);

        // Isolation of page 1 only
        reconf_req = 2'b10;
        tick();
        check("iso1_dout", dout_out, exp_iso1);
        dout_in = {ones49, pat49};
        #1;
        check("iso1_p0_pattern", dout_out[48:0], pat49);
        check("iso1_p1_zero", dout_out[97:49], 49'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
